// File: rtl/register_rename.sv
// Rename stage: RAT lookup, free-list allocation, per-PRF ready tracking and a registered RS insert packet.
// Optional RENAME_OUT_SNOOP_EN ORs a same-cycle CDB hit into the presented source ready flags.
module register_rename (
  input  logic       clk,
  input  logic       reset,
  input  logic       dec_valid,
  input  logic [4:0] dec_opcode,
  input  logic [4:0] dec_rs1,
  input  logic [4:0] dec_rs2,
  input  logic [4:0] dec_rd,
  input  logic       dec_rd_wen,
  input  logic       rs_full,
  output logic       dec_stall,
  input  logic       cdb_valid,
  input  logic [5:0] cdb_tag,
  input  logic       commit_valid,
  input  logic [5:0] commit_prf,
  output logic       rn_valid,
  output logic [4:0] rn_opcode,
  output logic [5:0] rn_src1_prf,
  output logic [5:0] rn_src2_prf,
  output logic       rn_src1_ready,
  output logic       rn_src2_ready,
  output logic [5:0] rn_dest_prf,
  output logic [5:0] rn_old_prf
);

  localparam int unsigned NUM_ARCH = 32;
  localparam int unsigned NUM_PRF  = 64;
  localparam int unsigned FL_DEPTH = NUM_PRF - NUM_ARCH;
  localparam int unsigned TAG_W    = 6;
  localparam int unsigned OP_W     = 5;
  localparam int unsigned PTR_W    = 5;
  localparam int unsigned CNT_W    = 6;

  logic [TAG_W-1:0]   r_rat [NUM_ARCH];
  logic [TAG_W-1:0]   r_fl  [FL_DEPTH];
  logic [PTR_W-1:0]   r_fl_head;
  logic [PTR_W-1:0]   r_fl_tail;
  logic [CNT_W-1:0]   r_fl_count;
  logic [NUM_PRF-1:0] r_ready;

  logic             r_rn_valid;
  logic [OP_W-1:0]  r_rn_opcode;
  logic [TAG_W-1:0] r_src1_prf;
  logic [TAG_W-1:0] r_src2_prf;
  logic             r_src1_ready;
  logic             r_src2_ready;
  logic [TAG_W-1:0] r_dest_prf;
  logic [TAG_W-1:0] r_old_prf;

  logic             w_alloc;
  logic             w_fl_empty;
  logic             w_fl_full;
  logic             w_accept;
  logic             w_pop;
  logic             w_push;
  logic [TAG_W-1:0] w_pop_prf;
  logic [TAG_W-1:0] w_src1_prf;
  logic [TAG_W-1:0] w_src2_prf;
  logic             w_src1_ready;
  logic             w_src2_ready;

  function automatic logic [PTR_W-1:0] fl_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FL_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_alloc    = dec_rd_wen && (dec_rd != '0);
  assign w_fl_empty = (r_fl_count == '0);
  assign w_fl_full  = (r_fl_count == CNT_W'(FL_DEPTH));
  assign dec_stall  = rs_full || (w_alloc && w_fl_empty);
  assign w_accept   = dec_valid && !dec_stall;
  assign w_pop      = w_accept && w_alloc;
  // A push into an empty list only becomes visible to pops on the following cycle.
  assign w_push     = commit_valid && (commit_prf != '0) && !w_fl_full;
  assign w_pop_prf  = r_fl[r_fl_head];

  // Lookups see the RAT before this edge's update, so rd==rs reads the old mapping.
  assign w_src1_prf   = (dec_rs1 == '0) ? '0 : r_rat[dec_rs1];
  assign w_src2_prf   = (dec_rs2 == '0) ? '0 : r_rat[dec_rs2];
  assign w_src1_ready = (dec_rs1 == '0) || r_ready[w_src1_prf] ||
                        (cdb_valid && (cdb_tag == w_src1_prf));
  assign w_src2_ready = (dec_rs2 == '0) || r_ready[w_src2_prf] ||
                        (cdb_valid && (cdb_tag == w_src2_prf));

  // RAT, free list and ready bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_ARCH; i++) r_rat[i] <= TAG_W'(i);
      for (int unsigned i = 0; i < FL_DEPTH; i++) r_fl[i] <= TAG_W'(NUM_ARCH + i);
      r_fl_head  <= '0;
      r_fl_tail  <= '0;
      r_fl_count <= CNT_W'(FL_DEPTH);
      r_ready    <= '1;
    end else begin
      if (w_pop) begin
        r_rat[dec_rd] <= w_pop_prf;
        r_fl_head     <= fl_next(r_fl_head);
      end
      if (w_push) begin
        r_fl[r_fl_tail] <= commit_prf;
        r_fl_tail       <= fl_next(r_fl_tail);
      end
      case ({w_push, w_pop})
        2'b10:   r_fl_count <= r_fl_count + CNT_W'(1);
        2'b01:   r_fl_count <= r_fl_count - CNT_W'(1);
        default: r_fl_count <= r_fl_count;
      endcase
      if (cdb_valid && (cdb_tag != '0)) r_ready[cdb_tag] <= 1'b1;
      // Later assignment: a fresh allocation's clear beats a same-edge broadcast.
      if (w_pop) r_ready[w_pop_prf] <= 1'b0;
    end
  end

  // Registered RS insert packet
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rn_valid   <= 1'b0;
      r_rn_opcode  <= '0;
      r_src1_prf   <= '0;
      r_src2_prf   <= '0;
      r_src1_ready <= 1'b0;
      r_src2_ready <= 1'b0;
      r_dest_prf   <= '0;
      r_old_prf    <= '0;
    end else if (w_accept) begin
      r_rn_valid   <= 1'b1;
      r_rn_opcode  <= dec_opcode;
      r_src1_prf   <= w_src1_prf;
      r_src2_prf   <= w_src2_prf;
      r_src1_ready <= w_src1_ready;
      r_src2_ready <= w_src2_ready;
      r_dest_prf   <= w_alloc ? w_pop_prf : '0;
      r_old_prf    <= w_alloc ? r_rat[dec_rd] : '0;
    end else begin
      r_rn_valid   <= 1'b0;
      r_rn_opcode  <= '0;
      r_src1_prf   <= '0;
      r_src2_prf   <= '0;
      r_src1_ready <= 1'b0;
      r_src2_ready <= 1'b0;
      r_dest_prf   <= '0;
      r_old_prf    <= '0;
    end
  end

  assign rn_valid    = r_rn_valid;
  assign rn_opcode   = r_rn_opcode;
  assign rn_src1_prf = r_src1_prf;
  assign rn_src2_prf = r_src2_prf;
  assign rn_dest_prf = r_dest_prf;
  assign rn_old_prf  = r_old_prf;

`ifdef RENAME_OUT_SNOOP_EN
  assign rn_src1_ready = r_src1_ready || (r_rn_valid && cdb_valid && (cdb_tag == r_src1_prf));
  assign rn_src2_ready = r_src2_ready || (r_rn_valid && cdb_valid && (cdb_tag == r_src2_prf));
`else
  assign rn_src1_ready = r_src1_ready;
  assign rn_src2_ready = r_src2_ready;
`endif

endmodule
